// File: rtl/lut_ram_arbiter_pkg.sv
// Shared types for the two-requester LUT RAM arbiter: FSM states, requester ids
// and the captured request record.
package lut_ram_arb_pkg;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        BUS = 1'b0,
        USR = 1'b1
    } req_id_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } req_t;

    // Grant vector layout is {usr, bus}.
    function automatic logic [1:0] id2onehot(input req_id_t id);
        return (id == USR) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lut_ram_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational; last_grant only moves
// when the owner accepts a request (advance_i).
module rr_arbiter2
    import lut_ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o,
    output req_id_t    win_o
);

    req_id_t last_q, last_d;

    always_comb begin
        win_o  = BUS;
        last_d = last_q;
        if (req_i == 2'b11)
            win_o = (last_q == BUS) ? USR : BUS;
        else if (req_i[1])
            win_o = USR;
        gnt_o = (req_i != 2'b00) ? id2onehot(win_o) : 2'b00;
        if (advance_i && (req_i != 2'b00))
            last_d = win_o;
    end

    // Reset to USR so the host bus wins the first contested cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= USR;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/lut_ram_arbiter.sv
// Shares one single-port registered-output LUT RAM between the host bus and user
// logic; one transaction at a time, fixed IDLE -> ACCESS -> RESP sequence.
module lut_ram_arbiter
    import lut_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_W,
    parameter int DATA_WIDTH = ARB_DATA_W,
    parameter int DEPTH      = 64,
    localparam int RAM_AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  bus_req_valid,
    output logic                  bus_req_ready,
    input  logic                  bus_req_we,
    input  logic [ADDR_WIDTH-1:0] bus_req_addr,
    input  logic [DATA_WIDTH-1:0] bus_req_wdata,
    output logic                  bus_rsp_valid,
    output logic [DATA_WIDTH-1:0] bus_rsp_rdata,
    output logic                  bus_rsp_err,

    input  logic                  usr_req_valid,
    output logic                  usr_req_ready,
    input  logic                  usr_req_we,
    input  logic [ADDR_WIDTH-1:0] usr_req_addr,
    input  logic [DATA_WIDTH-1:0] usr_req_wdata,
    output logic                  usr_rsp_valid,
    output logic [DATA_WIDTH-1:0] usr_rsp_rdata,
    output logic                  usr_rsp_err,

    output logic [RAM_AW-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata,

    output logic [1:0]            grant,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    state_t  state_q, state_d;
    req_t    req_q, req_d;
    req_id_t owner_q, owner_d;

    logic [1:0]            arb_gnt;
    req_id_t               arb_win;
    logic                  accept;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    assign accept = (state_q == IDLE) && (bus_req_valid || usr_req_valid);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     ({usr_req_valid, bus_req_valid}),
        .advance_i (accept),
        .gnt_o     (arb_gnt),
        .win_o     (arb_win)
    );

    // Range check looks at every address bit so aliases above DEPTH are rejected.
    assign in_range  = ({1'b0, req_q.addr} < DEPTH_W);
    assign rsp_rdata = (!req_q.we && in_range) ? ram_rdata : '0;

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        owner_d       = owner_q;
        bus_req_ready = 1'b0;
        usr_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = '0;
        bus_rsp_err   = 1'b0;
        usr_rsp_valid = 1'b0;
        usr_rsp_rdata = '0;
        usr_rsp_err   = 1'b0;
        ram_addr      = '0;
        ram_wdata     = '0;
        ram_we        = 1'b0;
        grant         = 2'b00;
        busy          = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                bus_req_ready = arb_gnt[0];
                usr_req_ready = arb_gnt[1];
                if (accept) begin
                    owner_d = arb_win;
                    if (arb_win == USR)
                        req_d = '{we: usr_req_we, addr: usr_req_addr, wdata: usr_req_wdata};
                    else
                        req_d = '{we: bus_req_we, addr: bus_req_addr, wdata: bus_req_wdata};
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                grant     = id2onehot(owner_q);
                ram_addr  = req_q.addr[RAM_AW-1:0];
                ram_wdata = req_q.wdata;
                ram_we    = req_q.we && in_range;
                state_d   = RESP;
            end
            RESP: begin
                grant = id2onehot(owner_q);
                if (owner_q == USR) begin
                    usr_rsp_valid = 1'b1;
                    usr_rsp_rdata = rsp_rdata;
                    usr_rsp_err   = !in_range;
                end else begin
                    bus_rsp_valid = 1'b1;
                    bus_rsp_rdata = rsp_rdata;
                    bus_rsp_err   = !in_range;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset drops straight to IDLE, so ram_we and any pending response vanish at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            owner_q <= BUS;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_lut_ram_arbiter.sv
// Directed bench for lut_ram_arbiter with a behavioural registered RAM and a
// shadow memory holding the expected contents.
module tb_lut_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        bus_req_valid, bus_req_ready, bus_req_we;
    logic [15:0] bus_req_addr, bus_req_wdata;
    logic        bus_rsp_valid, bus_rsp_err;
    logic [15:0] bus_rsp_rdata;
    logic        usr_req_valid, usr_req_ready, usr_req_we;
    logic [15:0] usr_req_addr, usr_req_wdata;
    logic        usr_rsp_valid, usr_rsp_err;
    logic [15:0] usr_rsp_rdata;
    logic [5:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [1:0]  grant;
    logic        busy;

    int vecs;
    int errs;

    logic [15:0] mem [0:63] = '{default: 16'h0};
    logic [15:0] shadow [0:63];

    lut_ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_we    (bus_req_we),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata),
        .bus_rsp_err   (bus_rsp_err),
        .usr_req_valid (usr_req_valid),
        .usr_req_ready (usr_req_ready),
        .usr_req_we    (usr_req_we),
        .usr_req_addr  (usr_req_addr),
        .usr_req_wdata (usr_req_wdata),
        .usr_rsp_valid (usr_rsp_valid),
        .usr_rsp_rdata (usr_rsp_rdata),
        .usr_rsp_err   (usr_rsp_err),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_we        (ram_we),
        .ram_rdata     (ram_rdata),
        .grant         (grant),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drop_all();
        bus_req_valid = 1'b0; bus_req_we = 1'b0; bus_req_addr = '0; bus_req_wdata = '0;
        usr_req_valid = 1'b0; usr_req_we = 1'b0; usr_req_addr = '0; usr_req_wdata = '0;
    endtask

    // One complete transaction from a single requester, entered from IDLE.
    task automatic txn(input bit usr, input bit we, input logic [15:0] addr, input logic [15:0] wd);
        logic [15:0] exp_rd;
        logic        inr;
        logic        rdy;
        int          n;
        inr    = (addr < 16'd64);
        exp_rd = (!we && inr) ? shadow[addr[5:0]] : 16'h0;
        @(negedge clk);
        if (usr) begin
            usr_req_valid = 1'b1; usr_req_we = we; usr_req_addr = addr; usr_req_wdata = wd;
        end else begin
            bus_req_valid = 1'b1; bus_req_we = we; bus_req_addr = addr; bus_req_wdata = wd;
        end
        #1;
        n = 0;
        rdy = usr ? usr_req_ready : bus_req_ready;
        while (!rdy && n < 8) begin
            @(negedge clk); #1;
            n++;
            rdy = usr ? usr_req_ready : bus_req_ready;
        end
        chk("txn_ready", 32'(rdy), 32'd1);
        @(negedge clk);
        drop_all();
        chk("txn_grant", 32'(grant), usr ? 32'd2 : 32'd1);
        chk("txn_ram_we", 32'(ram_we), 32'(we && inr));
        if (inr) chk("txn_ram_addr", 32'(ram_addr), 32'(addr[5:0]));
        chk("txn_rsp_quiet", 32'({bus_rsp_valid, usr_rsp_valid, bus_rsp_rdata, usr_rsp_rdata}), 32'd0);
        @(negedge clk);
        chk("txn_rsp_valid", 32'(usr ? usr_rsp_valid : bus_rsp_valid), 32'd1);
        chk("txn_other_quiet", 32'(usr ? bus_rsp_valid : usr_rsp_valid), 32'd0);
        chk("txn_rdata", 32'(usr ? usr_rsp_rdata : bus_rsp_rdata), 32'(exp_rd));
        chk("txn_err", 32'(usr ? usr_rsp_err : bus_rsp_err), 32'(!inr));
        if (we && inr) shadow[addr[5:0]] = wd;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        for (int i = 0; i < 64; i++) shadow[i] = 16'h0;
        rst_n = 1'b0;
        drop_all();

        // Reset state
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_rsp", 32'({bus_rsp_valid, usr_rsp_valid, bus_req_ready, usr_req_ready}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read-back
        txn(1'b0, 1'b1, 16'd5, 16'hBEEF);
        txn(1'b0, 1'b0, 16'd5, 16'h0);
        txn(1'b1, 1'b1, 16'd6, 16'h1234);
        txn(1'b1, 1'b0, 16'd6, 16'h0);

        // Both requesters continuously valid after reset: strict alternation
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_req_valid = 1'b1; bus_req_we = 1'b0; bus_req_addr = 16'd5;
        usr_req_valid = 1'b1; usr_req_we = 1'b0; usr_req_addr = 16'd6;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_bus_ready", 32'(bus_req_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_usr_ready", 32'(usr_req_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
            @(negedge clk);
            chk("rr_grant", 32'(grant), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_ram_addr", 32'(ram_addr), (k % 2 == 0) ? 32'd5 : 32'd6);
            @(negedge clk);
            chk("rr_bus_rsp", 32'(bus_rsp_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_usr_rsp", 32'(usr_rsp_valid), (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_rdata", (k % 2 == 0) ? 32'(bus_rsp_rdata) : 32'(usr_rsp_rdata),
                (k % 2 == 0) ? 32'hBEEF : 32'h1234);
            @(negedge clk); #1;
        end
        drop_all();

        // Range boundaries
        txn(1'b1, 1'b1, 16'd64, 16'hDEAD);
        txn(1'b0, 1'b0, 16'd64, 16'h0);
        txn(1'b0, 1'b1, 16'd63, 16'h6363);
        txn(1'b0, 1'b0, 16'd63, 16'h0);
        txn(1'b1, 1'b0, 16'd0, 16'h0);
        txn(1'b1, 1'b1, 16'hFFFF, 16'hAAAA);
        txn(1'b1, 1'b0, 16'd0, 16'h0);

        // Usr request rising mid-transaction waits for the next IDLE
        @(negedge clk);
        bus_req_valid = 1'b1; bus_req_we = 1'b0; bus_req_addr = 16'd5;
        #1;
        chk("wait_bus_ready", 32'(bus_req_ready), 32'd1);
        @(negedge clk);
        drop_all();
        usr_req_valid = 1'b1; usr_req_we = 1'b1; usr_req_addr = 16'd7; usr_req_wdata = 16'h7777;
        #1;
        chk("wait_usr_ready_T1", 32'(usr_req_ready), 32'd0);
        @(negedge clk);
        chk("wait_usr_ready_T2", 32'(usr_req_ready), 32'd0);
        chk("wait_bus_rsp", 32'({bus_rsp_valid, usr_rsp_valid}), 32'd2);
        chk("wait_bus_rdata", 32'(bus_rsp_rdata), 32'hBEEF);
        @(negedge clk); #1;
        chk("wait_usr_ready_T3", 32'(usr_req_ready), 32'd1);
        @(negedge clk);
        drop_all();
        chk("wait_ram_we", 32'({ram_we, grant}), 32'b110);
        chk("wait_ram_addr", 32'({ram_addr, ram_wdata}), {10'd0, 6'd7, 16'h7777});
        @(negedge clk);
        chk("wait_usr_rsp", 32'({usr_rsp_valid, usr_rsp_err, bus_rsp_valid}), 32'b100);
        shadow[7] = 16'h7777;
        txn(1'b0, 1'b0, 16'd7, 16'h0);

        // Reset while a write is in ACCESS
        @(negedge clk);
        bus_req_valid = 1'b1; bus_req_we = 1'b1; bus_req_addr = 16'd9; bus_req_wdata = 16'h9999;
        #1;
        chk("rst_mid_ready", 32'(bus_req_ready), 32'd1);
        @(negedge clk);
        drop_all();
        chk("rst_mid_we_before", 32'(ram_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we_drop", 32'(ram_we), 32'd0);
        chk("rst_mid_idle", 32'({busy, grant}), 32'd0);
        @(negedge clk);
        chk("rst_mid_no_rsp", 32'({bus_rsp_valid, usr_rsp_valid}), 32'd0);
        rst_n = 1'b1;
        bus_req_valid = 1'b1; bus_req_we = 1'b0; bus_req_addr = 16'd9;
        usr_req_valid = 1'b1; usr_req_we = 1'b0; usr_req_addr = 16'd5;
        #1;
        chk("rst_mid_bus_first", 32'({bus_req_ready, usr_req_ready}), 32'b10);
        @(negedge clk);
        drop_all();
        chk("rst_mid_grant", 32'(grant), 32'd1);
        @(negedge clk);
        chk("rst_mid_discarded", 32'({bus_rsp_valid, bus_rsp_rdata}), {15'd0, 1'b1, 16'h0});

        // Mixed traffic against the shadow memory
        for (int i = 0; i < 200; i++) begin
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 71)), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
